// File: rtl/mod_led_seq_if.sv
// Bus bundle for mod_led_seq: the shared instruction/data bus request side.
// master: CPU/bus side driving enables, addresses, write strobe and data.
// slave : the peripheral receiving them.
interface mod_led_seq_if;
    logic        ie;
    logic        de;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic        drw;
    logic [31:0] din;

    modport master (output ie, de, iaddr, daddr, drw, din);
    modport slave  (input  ie, de, iaddr, daddr, drw, din);
endinterface

// File: rtl/mod_led_seq.sv
// LED sequencer/dimmer peripheral. Software loads a static pattern, up to
// four pattern slots, a step period and a brightness. In sequence mode the
// slots are stepped through (looping or one-shot); a 16-level PWM gates the
// output while enabled. All state updates on the falling edge of clk.
// Ports:
//   clk  - system clock (state changes on negedge)
//   rst  - synchronous active-high reset, wins over a same-edge write
//   bus  - request side of the shared bus (ie/de/iaddr/daddr/drw/din)
//   iout - instruction read data: 0 while ie, else high-Z
//   dout - register read data while de, else high-Z
//   leds - registered drive for the 8 board LEDs
module mod_led_seq #(
    parameter int DIV_W = 24,
    parameter int NSLOT = 4
) (
    input  logic         clk,
    input  logic         rst,
    mod_led_seq_if.slave bus,
    output logic [31:0]  iout,
    output logic [31:0]  dout,
    output logic [7:0]   leds
);
    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_STATIC = 3'd1;
    localparam logic [2:0] A_DIV    = 3'd2;
    localparam logic [2:0] A_LEN    = 3'd3;

    logic             en;
    logic             seq;
    logic             oneshot;
    logic [3:0]       bright;
    logic [7:0]       static_pat;
    logic [DIV_W-1:0] div;
    logic [1:0]       len;
    logic [7:0]       slot [NSLOT];

    logic [DIV_W-1:0] cnt;
    logic [1:0]       idx;
    logic [3:0]       pwm;
    logic             done;

    logic [2:0]       sel;
    logic             wr;
    logic             restart;
    logic             run;
    logic             tick;
    logic             on;
    logic [DIV_W-1:0] div_last;
    logic [7:0]       pattern;
    logic [7:0]       leds_next;
    logic [31:0]      rdata;
    logic             unused_bits;

    assign sel     = bus.daddr[4:2];
    assign wr      = bus.de && bus.drw;
    // Any change to timing or sequence shape restarts the walk from slot 0.
    assign restart = wr && (sel == A_CTRL || sel == A_DIV || sel == A_LEN);
    assign run     = en && seq && !done;
    // DIV=0 behaves like DIV=1: terminal count of 0, tick every cycle.
    assign div_last = (div == '0) ? '0 : div - DIV_W'(1);
    assign tick     = run && (cnt >= div_last);
    assign on       = (pwm <= bright);
    assign pattern  = (en && seq) ? slot[idx] : static_pat;
    assign leds_next = !en ? static_pat : (on ? pattern : 8'h00);

    assign unused_bits = ^{bus.iaddr, bus.daddr, bus.din};

    always_comb begin
        rdata = 32'h0;
        case (sel)
            A_CTRL:   rdata = {24'h0, bright, 1'b0, oneshot, seq, en};
            A_STATIC: rdata = {24'h0, static_pat};
            A_DIV:    rdata = 32'(div);
            A_LEN:    rdata = {21'h0, done, idx, 6'h0, len};
            default:  rdata = {24'h0, slot[sel[1:0]]};
        endcase
    end

    assign dout = bus.de ? rdata : 32'bz;
    assign iout = bus.ie ? 32'h0 : 32'bz;

    always_ff @(negedge clk) begin
        if (rst) begin
            en         <= 1'b0;
            seq        <= 1'b0;
            oneshot    <= 1'b0;
            bright     <= 4'h0;
            static_pat <= 8'hff;
            div        <= DIV_W'(1);
            len        <= 2'd0;
            for (int i = 0; i < NSLOT; i++) slot[i] <= 8'h00;
            cnt        <= '0;
            idx        <= 2'd0;
            pwm        <= 4'h0;
            done       <= 1'b0;
            leds       <= 8'hff;
        end else begin
            pwm  <= pwm + 4'd1;
            leds <= leds_next;

            if (wr) begin
                case (sel)
                    A_CTRL: begin
                        en      <= bus.din[0];
                        seq     <= bus.din[1];
                        oneshot <= bus.din[2];
                        bright  <= bus.din[7:4];
                    end
                    A_STATIC: static_pat <= bus.din[7:0];
                    A_DIV:    div        <= bus.din[DIV_W-1:0];
                    A_LEN:    len        <= bus.din[1:0];
                    default:  slot[sel[1:0]] <= bus.din[7:0];
                endcase
            end

            if (restart) begin
                cnt  <= '0;
                idx  <= 2'd0;
                done <= 1'b0;
            end else if (tick) begin
                cnt <= '0;
                if (idx != len)
                    idx <= idx + 2'd1;
                else if (oneshot)
                    done <= 1'b1;
                else
                    idx <= 2'd0;
            end else if (run) begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mod_led_seq.sv
// Self-checking bench for mod_led_seq. The reference model tracks register
// contents plus two counters: run cycles since the last restart and total
// cycles since reset. Slot index, done and PWM phase are derived from those
// with plain division/modulo.
module tb_mod_led_seq;
    logic        clk;
    logic        rst;
    logic [31:0] iout;
    logic [31:0] dout;
    logic [7:0]  leds;

    mod_led_seq_if bus ();

    mod_led_seq #(.DIV_W(24), .NSLOT(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .iout (iout),
        .dout (dout),
        .leds (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit          m_en, m_seq, m_one;
    logic [3:0]  m_bright;
    logic [7:0]  m_static;
    logic [23:0] m_div;
    int          m_len;
    logic [7:0]  m_slot [4];
    int          m_t;
    int          m_cyc;
    logic [7:0]  m_leds;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_k();
        int p;
        p = (m_div == 0) ? 1 : int'(m_div);
        return m_t / p;
    endfunction

    function automatic bit m_done();
        return m_one && (m_k() > m_len);
    endfunction

    function automatic int m_idx();
        if (m_one) return (m_k() > m_len) ? m_len : m_k();
        return m_k() % (m_len + 1);
    endfunction

    function automatic logic [31:0] m_read(input int a);
        logic [1:0] i2, l2;
        i2 = 2'(m_idx());
        l2 = 2'(m_len);
        case (a)
            0: return {24'h0, m_bright, 1'b0, m_one, m_seq, m_en};
            1: return {24'h0, m_static};
            2: return {8'h0, m_div};
            3: return {21'h0, m_done(), i2, 6'h0, l2};
            default: return {24'h0, m_slot[a-4]};
        endcase
    endfunction

    task automatic model_edge(input bit wr, input int a, input logic [31:0] d, input bit r);
        bit run;
        logic [7:0] pat;
        if (r) begin
            m_en = 0; m_seq = 0; m_one = 0; m_bright = 4'h0;
            m_static = 8'hff; m_div = 24'd1; m_len = 0;
            for (int i = 0; i < 4; i++) m_slot[i] = 8'h00;
            m_t = 0; m_cyc = 0; m_leds = 8'hff;
            return;
        end
        pat = (m_en && m_seq) ? m_slot[m_idx()] : m_static;
        m_leds = !m_en ? m_static : (((m_cyc % 16) <= int'(m_bright)) ? pat : 8'h00);
        run = m_en && m_seq && !m_done();
        m_cyc++;
        if (run) m_t++;
        if (wr) begin
            case (a)
                0: begin
                    m_en = d[0]; m_seq = d[1]; m_one = d[2]; m_bright = d[7:4];
                    m_t = 0;
                end
                1: m_static = d[7:0];
                2: begin m_div = d[23:0]; m_t = 0; end
                3: begin m_len = int'(d[1:0]); m_t = 0; end
                default: m_slot[a-4] = d[7:0];
            endcase
        end
    endtask

    // Called just after a posedge: drive, let the negedge act, check at next posedge.
    task automatic step(input bit wr, input int a, input logic [31:0] d, input bit r);
        rst       = r;
        bus.de    = wr;
        bus.drw   = wr;
        bus.daddr = {27'h0, 3'(a), 2'b00};
        bus.din   = d;
        @(negedge clk);
        model_edge(wr, a, d, r);
        @(posedge clk);
        chk("leds", {24'h0, leds}, {24'h0, m_leds});
        rst     = 1'b0;
        bus.de  = 1'b0;
        bus.drw = 1'b0;
    endtask

    task automatic wr_reg(input int a, input logic [31:0] d);
        step(1'b1, a, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 32'h0, 1'b0);
    endtask

    task automatic rd_chk(input string tag, input int a);
        bus.de    = 1'b1;
        bus.drw   = 1'b0;
        bus.daddr = {27'h0, 3'(a), 2'b00};
        #1;
        chk(tag, dout, m_read(a));
        bus.de = 1'b0;
    endtask

    initial begin
        int on_cnt;
        rst = 1'b1;
        bus.ie = 1'b0; bus.de = 1'b0; bus.drw = 1'b0;
        bus.iaddr = 32'h0; bus.daddr = 32'h0; bus.din = 32'h0;
        @(posedge clk);

        // 1: reset and idle
        step(1'b0, 0, 32'h0, 1'b1);
        step(1'b0, 0, 32'h0, 1'b1);
        idle(3);
        chk("reset_leds", {24'h0, leds}, 32'h0000_00ff);
        rd_chk("reset_ctrl", 0);
        chk("reset_ctrl_const", dout, 32'h0);
        rd_chk("reset_len", 3);
        chk("reset_len_const", dout, 32'h0);
        rd_chk("reset_div", 2);
        bus.ie = 1'b1; bus.iaddr = $urandom;
        #1 chk("iout_zero", iout, 32'h0);
        bus.ie = 1'b0;

        // 2: static pattern, then enabled with full brightness
        wr_reg(1, 32'h0000_005a);
        step(1'b0, 0, 32'h0, 1'b0);
        chk("static_5a", {24'h0, leds}, 32'h5a);
        wr_reg(0, 32'h0000_00f1);
        idle(20);
        chk("static_en_5a", {24'h0, leds}, 32'h5a);

        // 3: looping sequence
        wr_reg(4, 32'h01); wr_reg(5, 32'h02); wr_reg(6, 32'h04); wr_reg(7, 32'h08);
        wr_reg(3, 32'h3);
        wr_reg(2, 32'h3);
        wr_reg(0, 32'hf3);
        for (int s = 0; s < 5; s++) begin
            step(1'b0, 0, 32'h0, 1'b0);
            chk("seq_order", {24'h0, leds}, 32'(8'h01 << (s % 4)));
            rd_chk("seq_status", 3);
            idle(2);
        end

        // 4: one-shot halts on the last slot, CTRL rewrite restarts
        wr_reg(0, 32'hf7);
        idle(20);
        chk("oneshot_hold", {24'h0, leds}, 32'h08);
        rd_chk("oneshot_done", 3);
        chk("oneshot_done_bit", {31'h0, dout[10]}, 32'h1);
        wr_reg(0, 32'hf7);
        rd_chk("restart_status", 3);
        step(1'b0, 0, 32'h0, 1'b0);
        chk("restart_01", {24'h0, leds}, 32'h01);

        // 5: PWM duty
        wr_reg(1, 32'hff);
        wr_reg(0, 32'h31);
        idle(3);
        on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 0, 32'h0, 1'b0);
            if (leds == 8'hff) on_cnt++;
        end
        chk("duty_b3", 32'(on_cnt), 32'd4);
        wr_reg(0, 32'h01);
        idle(3);
        on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 0, 32'h0, 1'b0);
            if (leds == 8'hff) on_cnt++;
        end
        chk("duty_b0", 32'(on_cnt), 32'd1);

        // 6: reset mid-sequence together with a SLOT2 write
        wr_reg(0, 32'hf3);
        idle(7);
        step(1'b1, 6, 32'h0000_0055, 1'b1);
        chk("rst_leds", {24'h0, leds}, 32'hff);
        rd_chk("rst_slot2", 6);
        chk("rst_slot2_zero", dout, 32'h0);
        rd_chk("rst_status", 3);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int r;
            int a;
            logic [31:0] d;
            r = $urandom_range(0, 99);
            a = $urandom_range(0, 7);
            d = $urandom;
            if (a == 2) d = $urandom_range(0, 4);
            if (a == 0 && $urandom_range(0, 3) != 0) d[1:0] = 2'b11;
            if (r < 1)
                step($urandom_range(0, 1) == 1, a, d, 1'b1);
            else if (r < 6)
                step(1'b1, a, d, 1'b0);
            else
                step(1'b0, 0, 32'h0, 1'b0);
            if ($urandom_range(0, 7) == 0) rd_chk("rand_rd", $urandom_range(0, 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
